// File: rtl/ehgu_fifo_wr_arb_pkg.sv
// Shared types for the ehgu FIFO write-side arbiter.
// Holds the arbiter state encoding and the width of the per-grant beat counter.
package ehgu_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    STALL
  } arbState_t;

  // Wide enough for MAX_BURST up to 15
  localparam int BEAT_W = 4;

endpackage

// File: rtl/ehgu_fifo_wr_arb_if.sv
// Requester, FIFO write and occupancy signals of the ehgu FIFO write arbiter.
// The slave modport is the arbiter side; master is the client/FIFO side.
interface ehgu_fifo_wr_arb_if #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  wenable;
  logic [WIDTH-1:0]      wdata;
  logic                  rd_pop;
  logic [CWIDTH-1:0]     level;
  logic                  full;
  logic                  empty;
  logic                  err_underflow;

  modport master (
    output req, req_data, rd_pop,
    input  gnt, wenable, wdata, level, full, empty, err_underflow
  );

  modport slave (
    input  req, req_data, rd_pop,
    output gnt, wenable, wdata, level, full, empty, err_underflow
  );

endinterface

// File: rtl/ehgu_fifo_wr_arb_rr_pick.sv
// Combinational round-robin selector: first active request at or after
// (i_last + 1) mod NREQ, wrapping around.
module ehgu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Walk candidates in priority order; the first hit wins
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, i_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      w_cand = w_sum[IW-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ehgu_fifo_wr_arb.sv
// Write-side arbiter for the ehgu FIFO: round-robin bounded bursts onto the
// single FIFO write port, plus occupancy tracking from wclk-domain pop pulses.
module ehgu_fifo_wr_arb
  import ehgu_fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int MAX_BURST = 4,
  parameter int CWIDTH    = $clog2(DEPTH+1)
) (
  input  logic             wclk,
  input  logic             rstn,
  ehgu_fifo_wr_arb_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  arbState_t         r_state, w_stateNext;
  logic [NREQ-1:0]   r_gnt, w_gntNext;
  logic [IW-1:0]     r_last, w_lastNext;
  logic [BEAT_W-1:0] r_beatCnt, w_beatNext;
  logic [CWIDTH-1:0] r_level;
  logic              r_wen;
  logic [WIDTH-1:0]  r_wdata, w_selData;
  logic              r_errUnder;

  logic              w_full, w_empty, w_grantedReq, w_accept, w_pop;
  logic [NREQ-1:0]   w_pickOneHot;
  logic [IW-1:0]     w_pickIdx;
  logic              w_pickValid;

  assign w_full       = (r_level == CWIDTH'(DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_grantedReq = |(r_gnt & bus.req);
  assign w_accept     = w_grantedReq & ~w_full;
  assign w_pop        = bus.rd_pop & ~w_empty;

  ehgu_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_onehot (w_pickOneHot),
    .o_idx    (w_pickIdx),
    .o_valid  (w_pickValid)
  );

  always_comb begin
    w_selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_selData = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // BURST and STALL share one rule set: an accept counts a beat, a dropped
  // request releases, a blocked-but-still-requesting grant waits in STALL
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    w_lastNext  = r_last;
    w_beatNext  = r_beatCnt;
    case (r_state)
      IDLE: begin
        w_gntNext = '0;
        if (w_pickValid && !w_full) begin
          w_gntNext   = w_pickOneHot;
          w_lastNext  = w_pickIdx;
          w_beatNext  = '0;
          w_stateNext = BURST;
        end
      end
      BURST, STALL: begin
        if (w_accept) begin
          w_beatNext = r_beatCnt + BEAT_W'(1);
          if (r_beatCnt == BEAT_W'(MAX_BURST-1)) begin
            w_gntNext   = '0;
            w_stateNext = IDLE;
          end else begin
            w_stateNext = BURST;
          end
        end else if (!w_grantedReq) begin
          w_gntNext   = '0;
          w_stateNext = IDLE;
        end else begin
          w_stateNext = STALL;
        end
      end
      default: begin
        w_gntNext   = '0;
        w_stateNext = IDLE;
      end
    endcase
  end

  // Last winner starts at NREQ-1 so requester 0 is first after reset
  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_last    <= IW'(NREQ-1);
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_gnt     <= w_gntNext;
      r_last    <= w_lastNext;
      r_beatCnt <= w_beatNext;
    end
  end

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_level    <= '0;
      r_errUnder <= 1'b0;
    end else begin
      r_wen   <= w_accept;
      if (w_accept) begin
        r_wdata <= w_selData;
      end
      r_level <= r_level + CWIDTH'(w_accept) - CWIDTH'(w_pop);
      if (bus.rd_pop && w_empty) begin
        r_errUnder <= 1'b1;
      end
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.wenable       = r_wen;
  assign bus.wdata         = r_wdata;
  assign bus.level         = r_level;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.err_underflow = r_errUnder;

endmodule

// File: tb/tb_ehgu_fifo_wr_arb.sv
// Directed bench for ehgu_fifo_wr_arb: stimulus pushes expected write data into
// a queue, a negedge monitor pops and compares on every wenable.
module tb_ehgu_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int MAX_BURST = 4;
  localparam int CWIDTH = 8;

  logic wclk;
  logic rstn;
  int   errors;
  int   checks;
  logic [WIDTH-1:0] sbq[$];

  ehgu_fifo_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CWIDTH(CWIDTH)) bus ();

  ehgu_fifo_wr_arb #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .CWIDTH(CWIDTH)
  ) dut (
    .wclk (wclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected beat
  always @(negedge wclk) begin
    logic [WIDTH-1:0] expData;
    if (rstn === 1'b1 && bus.wenable === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: got wdata %0h expected no write at %0t", bus.wdata, $time);
      end else begin
        expData = sbq.pop_front();
        checkOutput("wdata", 32'(bus.wdata), 32'(expData));
      end
    end
  end

  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic pushN(input logic [WIDTH-1:0] d, input int n);
    for (int i = 0; i < n; i++) sbq.push_back(d);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    bus.req = '0;
    bus.rd_pop = 1'b0;
    #3;
    checkOutput("pendingWrites", 32'(sbq.size()), 0);
    sbq.delete();
    @(negedge wclk);
    @(negedge wclk);
    checkOutput("rstGnt", 32'(bus.gnt), 0);
    checkOutput("rstWen", 32'(bus.wenable), 0);
    checkOutput("rstWdata", 32'(bus.wdata), 0);
    checkOutput("rstLevel", 32'(bus.level), 0);
    checkOutput("rstFull", 32'(bus.full), 0);
    checkOutput("rstEmpty", 32'(bus.empty), 1);
    checkOutput("rstErr", 32'(bus.err_underflow), 0);
    rstn = 1'b1;
  endtask

  task automatic applyStimulus();
    logic [NREQ-1:0] expGnt;
    logic            expWen;
    int              waitCnt;

    // All four requesting: 4-beat bursts 0,1,2,3,0 with one idle cycle between
    doReset();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
    pushN(8'hA0, 4); pushN(8'hA1, 4); pushN(8'hA2, 4); pushN(8'hA3, 4); pushN(8'hA0, 3);
    bus.req = 4'b1111;
    for (int k = 1; k <= 24; k++) begin
      tick();
      expGnt = (((k-1) % 5) < 4) ? NREQ'(1 << (((k-1) / 5) % 4)) : '0;
      expWen = (k >= 2) && (((k-2) % 5) < 4);
      checkOutput($sformatf("rrGnt%0d", k), 32'(bus.gnt), 32'(expGnt));
      checkOutput($sformatf("rrWen%0d", k), 32'(bus.wenable), 32'(expWen));
      if (k == 24) bus.req = '0;
    end
    tick(); tick(); tick();
    #1;
    checkOutput("rrLevel", 32'(bus.level), 19);
    checkOutput("rrDrained", 32'(sbq.size()), 0);

    // Sole requester 2 drops after two beats, then wins again
    doReset();
    bus.req_data[2*WIDTH +: WIDTH] = 8'h51;
    pushN(8'h51, 1); pushN(8'h52, 1);
    bus.req = 4'b0100;
    tick();
    checkOutput("dropGnt1", 32'(bus.gnt), 32'h4);
    tick();
    bus.req_data[2*WIDTH +: WIDTH] = 8'h52;
    tick();
    bus.req = '0;
    tick();
    checkOutput("dropGntClr", 32'(bus.gnt), 0);
    bus.req = 4'b0100;
    tick();
    checkOutput("dropGnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();
    checkOutput("dropGntClr2", 32'(bus.gnt), 0);
    tick();
    #1;
    checkOutput("dropLevel", 32'(bus.level), 2);
    checkOutput("dropDrained", 32'(sbq.size()), 0);

    // Fill to DEPTH with no pops
    doReset();
    bus.req_data[0 +: WIDTH] = 8'hC0;
    pushN(8'hC0, DEPTH);
    bus.req = 4'b0001;
    waitCnt = 0;
    while (bus.full !== 1'b1 && waitCnt < 400) begin
      tick();
      waitCnt++;
    end
    checkOutput("fillReached", 32'(bus.full), 1);
    for (int k = 0; k < 6; k++) tick();
    #1;
    checkOutput("fillLevel", 32'(bus.level), DEPTH);
    checkOutput("fillFull", 32'(bus.full), 1);
    checkOutput("fillEmpty", 32'(bus.empty), 0);
    checkOutput("fillGnt", 32'(bus.gnt), 0);
    checkOutput("fillDrained", 32'(sbq.size()), 0);

    // One pop at full lets exactly one beat in, then the grant stalls
    bus.rd_pop = 1'b1;
    pushN(8'hC0, 1);
    tick();
    bus.rd_pop = 1'b0;
    checkOutput("popLevel", 32'(bus.level), DEPTH-1);
    checkOutput("popFull", 32'(bus.full), 0);
    tick();
    checkOutput("popGnt", 32'(bus.gnt), 1);
    tick();
    checkOutput("refillLevel", 32'(bus.level), DEPTH);
    checkOutput("refillFull", 32'(bus.full), 1);
    tick(); tick(); tick();
    #1;
    checkOutput("stallGnt", 32'(bus.gnt), 1);
    checkOutput("stallLevel", 32'(bus.level), DEPTH);
    checkOutput("stallDrained", 32'(sbq.size()), 0);

    // Pop while full (blocked accept), then accept+pop together
    bus.rd_pop = 1'b1;
    pushN(8'hC0, 2);
    tick();
    checkOutput("blockLevel", 32'(bus.level), DEPTH-1);
    tick();
    checkOutput("bothLevel", 32'(bus.level), DEPTH-1);
    bus.rd_pop = 1'b0;
    tick();
    checkOutput("afterLevel", 32'(bus.level), DEPTH);
    tick(); tick(); tick();
    #1;
    checkOutput("afterDrained", 32'(sbq.size()), 0);

    // Pop at empty is ignored and latches the sticky error
    doReset();
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    checkOutput("underLevel", 32'(bus.level), 0);
    checkOutput("underErr", 32'(bus.err_underflow), 1);
    checkOutput("underEmpty", 32'(bus.empty), 1);
    tick(); tick(); tick();
    checkOutput("underSticky", 32'(bus.err_underflow), 1);

    // Async reset in the middle of a burst
    doReset();
    bus.req_data[0 +: WIDTH] = 8'h66;
    pushN(8'h66, 2);
    bus.req = 4'b0001;
    tick(); tick(); tick();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midGnt", 32'(bus.gnt), 0);
    checkOutput("midWen", 32'(bus.wenable), 0);
    checkOutput("midLevel", 32'(bus.level), 0);
    checkOutput("midEmpty", 32'(bus.empty), 1);
    checkOutput("midWrites", 32'(sbq.size()), 0);
    @(negedge wclk);
    rstn = 1'b1;
    bus.req = 4'b1111;
    tick();
    checkOutput("postRstGnt", 32'(bus.gnt), 1);
    bus.req = '0;
    tick(); tick();
    doReset();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.rd_pop = 1'b0;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end of run expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
